// File: rtl/opendap_swd_pkg.sv
// Shared SWD definitions: ACK codes, host engine state encoding, request header payload.
package opendap_swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam int unsigned LINERESET_LEN = 56;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned HDR_W         = 8;
  localparam int unsigned ACK_W         = 3;
  localparam int unsigned CNT_W         = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_HEADER,
    ST_TURN_ACK,
    ST_ACK,
    ST_RDATA,
    ST_TURN_RD,
    ST_TURN_WR,
    ST_WDATA,
    ST_TURN_NAK,
    ST_LINERESET,
    ST_TRAIL
  } host_state_e;

  typedef struct packed {
    logic       ap_ndp;
    logic       r_nw;
    logic [1:0] addr;
  } swd_hdr_t;

  // Packet header, bit 0 goes on the wire first.
  function automatic logic [HDR_W-1:0] swd_header(input swd_hdr_t h);
    return {1'b1, 1'b0, h.ap_ndp ^ h.r_nw ^ h.addr[0] ^ h.addr[1],
            h.addr[1], h.addr[0], h.r_nw, h.ap_ndp, 1'b1};
  endfunction

endpackage

// File: rtl/opendap_swd_host_clkgen.sv
// SWCLK divider: alternating fall/rise ticks every CLKDIV clk cycles while enabled.
module opendap_swd_host_clkgen #(
  parameter int unsigned CLKDIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_stop,
  output logic swclk_out,
  output logic o_fall_tick_c,
  output logic o_rise_tick_c
);

  localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic             r_phase;
  logic             w_tick;

  assign w_tick        = i_en && (r_div == DIV_W'(CLKDIV - 1));
  assign o_fall_tick_c = w_tick && !r_phase;
  assign o_rise_tick_c = w_tick && r_phase;

  // i_stop suppresses the rising edge of the final slot so SWCLK returns to idle low cleanly.
  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_div     <= '0;
      r_phase   <= 1'b0;
      swclk_out <= 1'b0;
    end else if (w_tick) begin
      r_div     <= '0;
      r_phase   <= ~r_phase;
      swclk_out <= r_phase && !i_stop;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

endmodule

// File: rtl/opendap_swd_host_serial.sv
// Host-side SWD serial engine: header out, ACK in, 32-bit data + parity, line reset.
// IDLE_CYCLES must be at least 1.
module opendap_swd_host_serial
  import opendap_swd_pkg::*;
#(
  parameter int unsigned CLKDIV      = 2,
  parameter int unsigned IDLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              swclk_out,
  output logic              swdo,
  output logic              swdo_en,
  input  logic              swdi,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_linereset,
  input  logic              req_ap_ndp,
  input  logic              req_r_nw,
  input  logic [1:0]        req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [ACK_W-1:0]  rsp_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_parity_err
);

  host_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  swd_hdr_t          r_hdr, w_hdr_nxt;
  logic [DATA_W-1:0] r_shift, w_shift_nxt;
  logic              r_par, w_par_nxt;
  logic [ACK_W-1:0]  r_ack, w_ack_nxt, w_ack_full;
  logic              r_rd_ok, w_rd_ok_nxt;
  logic              r_perr, w_perr_nxt;
  logic              w_swdo_nxt, w_swdo_en_nxt;
  logic              w_rsp_valid_nxt, w_rsp_perr_nxt;
  logic [ACK_W-1:0]  w_rsp_ack_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic [HDR_W-1:0]  w_hdr_bits;
  logic              w_fall, w_rise, w_last;

  assign req_ready  = (r_state == ST_IDLE);
  assign w_hdr_bits = swd_header(r_hdr);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_ack_full = {swdi, r_ack[ACK_W-1:1]};
  assign w_last     = (r_state == ST_TRAIL) && (r_cnt == CNT_W'(IDLE_CYCLES - 1));

  opendap_swd_host_clkgen #(
    .CLKDIV(CLKDIV)
  ) u_clkgen (
    .clk          (clk),
    .rst          (rst),
    .i_en         (r_state != ST_IDLE),
    .i_stop       (w_last),
    .swclk_out    (swclk_out),
    .o_fall_tick_c(w_fall),
    .o_rise_tick_c(w_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_hdr          <= '0;
      r_shift        <= '0;
      r_par          <= 1'b0;
      r_ack          <= '0;
      r_rd_ok        <= 1'b0;
      r_perr         <= 1'b0;
      swdo           <= 1'b0;
      swdo_en        <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_ack        <= '0;
      rsp_rdata      <= '0;
      rsp_parity_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_hdr          <= w_hdr_nxt;
      r_shift        <= w_shift_nxt;
      r_par          <= w_par_nxt;
      r_ack          <= w_ack_nxt;
      r_rd_ok        <= w_rd_ok_nxt;
      r_perr         <= w_perr_nxt;
      swdo           <= w_swdo_nxt;
      swdo_en        <= w_swdo_en_nxt;
      rsp_valid      <= w_rsp_valid_nxt;
      rsp_ack        <= w_rsp_ack_nxt;
      rsp_rdata      <= w_rsp_rdata_nxt;
      rsp_parity_err <= w_rsp_perr_nxt;
    end
  end

  // Pins change on fall ticks; sampling and state advance happen on rise ticks.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_hdr_nxt       = r_hdr;
    w_shift_nxt     = r_shift;
    w_par_nxt       = r_par;
    w_ack_nxt       = r_ack;
    w_rd_ok_nxt     = r_rd_ok;
    w_perr_nxt      = r_perr;
    w_swdo_nxt      = swdo;
    w_swdo_en_nxt   = swdo_en;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_ack_nxt   = rsp_ack;
    w_rsp_rdata_nxt = rsp_rdata;
    w_rsp_perr_nxt  = rsp_parity_err;

    if (w_fall) begin
      w_swdo_en_nxt = 1'b0;
      w_swdo_nxt    = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_hdr_nxt   = '{ap_ndp: req_ap_ndp, r_nw: req_r_nw, addr: req_addr};
          w_shift_nxt = req_wdata;
          w_par_nxt   = req_r_nw ? 1'b0 : ^req_wdata;
          w_cnt_nxt   = '0;
          w_ack_nxt   = '0;
          w_rd_ok_nxt = 1'b0;
          w_perr_nxt  = 1'b0;
          w_state_nxt = req_linereset ? ST_LINERESET : ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (w_fall) begin
          w_swdo_en_nxt = 1'b1;
          w_swdo_nxt    = w_hdr_bits[r_cnt[2:0]];
        end
        if (w_rise) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == CNT_W'(HDR_W - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_TURN_ACK;
          end
        end
      end
      ST_TURN_ACK: begin
        if (w_rise) w_state_nxt = ST_ACK;
      end
      ST_ACK: begin
        if (w_rise) begin
          w_ack_nxt = w_ack_full;
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == CNT_W'(ACK_W - 1)) begin
            w_cnt_nxt = '0;
            if (w_ack_full == ACK_OK) begin
              w_rd_ok_nxt = r_hdr.r_nw;
              w_state_nxt = r_hdr.r_nw ? ST_RDATA : ST_TURN_WR;
            end else begin
              w_state_nxt = ST_TURN_NAK;
            end
          end
        end
      end
      ST_RDATA: begin
        if (w_rise) begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            w_perr_nxt  = swdi ^ r_par;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_TURN_RD;
          end else begin
            w_shift_nxt = {swdi, r_shift[DATA_W-1:1]};
            w_par_nxt   = r_par ^ swdi;
            w_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      ST_TURN_WR: begin
        if (w_rise) w_state_nxt = ST_WDATA;
      end
      ST_WDATA: begin
        if (w_fall) begin
          w_swdo_en_nxt = 1'b1;
          w_swdo_nxt    = (r_cnt == CNT_W'(DATA_W)) ? r_par : r_shift[0];
        end
        if (w_rise) begin
          if (r_cnt == CNT_W'(DATA_W)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_TRAIL;
          end else begin
            w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
            w_cnt_nxt   = w_cnt_inc;
          end
        end
      end
      ST_TURN_RD, ST_TURN_NAK: begin
        if (w_rise) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_TRAIL;
        end
      end
      ST_LINERESET: begin
        if (w_fall) begin
          w_swdo_en_nxt = 1'b1;
          w_swdo_nxt    = 1'b1;
        end
        if (w_rise) begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == CNT_W'(LINERESET_LEN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_TRAIL;
          end
        end
      end
      ST_TRAIL: begin
        if (w_fall) begin
          w_swdo_en_nxt = 1'b1;
          w_swdo_nxt    = 1'b0;
        end
        if (w_rise) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_last) begin
            w_cnt_nxt       = '0;
            w_state_nxt     = ST_IDLE;
            w_swdo_en_nxt   = 1'b0;
            w_swdo_nxt      = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_ack_nxt   = r_ack;
            w_rsp_rdata_nxt = r_rd_ok ? r_shift : '0;
            w_rsp_perr_nxt  = r_perr;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_opendap_swd_host_serial.sv
// Directed bench: slot-level wire model of each SWD packet, checked every clk cycle.
module tb_opendap_swd_host_serial;

  localparam int unsigned CLKDIV      = 2;
  localparam int unsigned IDLE_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swclk_out, swdo, swdo_en;
  logic        swdi = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic        req_linereset = 1'b0, req_ap_ndp = 1'b0, req_r_nw = 1'b0;
  logic [1:0]  req_addr = 2'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid, rsp_parity_err;
  logic [2:0]  rsp_ack;
  logic [31:0] rsp_rdata;

  always #5 clk = ~clk;

  opendap_swd_host_serial #(
    .CLKDIV(CLKDIV),
    .IDLE_CYCLES(IDLE_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .swclk_out(swclk_out), .swdo(swdo), .swdo_en(swdo_en),
    .swdi(swdi), .req_valid(req_valid), .req_ready(req_ready),
    .req_linereset(req_linereset), .req_ap_ndp(req_ap_ndp), .req_r_nw(req_r_nw),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_parity_err(rsp_parity_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Wire model: per SWCLK slot, what the host drives and what the target answers.
  bit          exp_en [0:63];
  bit          exp_do [0:63];
  bit          tgt    [0:63];
  int          L;
  logic [2:0]  exp_ack;
  logic [31:0] exp_rdata;
  logic        exp_perr;

  int  n;
  bit  mon_active = 1'b0;
  int  abort_at = 0;
  int  valid_n;
  bit  got_do [0:63];
  bit  got_en [0:63];

  task automatic build_model(input bit lr, input bit ap, input bit rnw, input logic [1:0] a,
                             input logic [31:0] wd, input logic [2:0] ack_t,
                             input logic [31:0] rd_t, input bit bad_par);
    bit hdr [0:7];
    int s;
    for (int i = 0; i < 64; i++) begin
      exp_en[i] = 0; exp_do[i] = 0; tgt[i] = 0;
    end
    exp_ack = 3'b000; exp_rdata = 32'd0; exp_perr = 1'b0;
    if (lr) begin
      for (int i = 0; i < 56; i++) begin exp_en[i] = 1; exp_do[i] = 1; end
      s = 56;
    end else begin
      hdr[0] = 1; hdr[1] = ap; hdr[2] = rnw; hdr[3] = a[0]; hdr[4] = a[1];
      hdr[5] = ap ^ rnw ^ a[0] ^ a[1]; hdr[6] = 0; hdr[7] = 1;
      for (int i = 0; i < 8; i++) begin exp_en[i] = 1; exp_do[i] = hdr[i]; end
      for (int i = 0; i < 3; i++) tgt[9 + i] = ack_t[i];
      exp_ack = ack_t;
      if (ack_t == 3'b001 && rnw) begin
        for (int i = 0; i < 32; i++) tgt[12 + i] = rd_t[i];
        tgt[44] = (^rd_t) ^ bad_par;
        exp_rdata = rd_t;
        exp_perr = bad_par;
        s = 46;
      end else if (ack_t == 3'b001) begin
        for (int i = 0; i < 32; i++) begin exp_en[13 + i] = 1; exp_do[13 + i] = wd[i]; end
        exp_en[45] = 1; exp_do[45] = ^wd;
        s = 46;
      end else begin
        s = 13;
      end
    end
    for (int i = 0; i < int'(IDLE_CYCLES); i++) begin exp_en[s + i] = 1; exp_do[s + i] = 0; end
    L = s + int'(IDLE_CYCLES);
  endtask

  // Compare process: SWCLK cycle = 4 clk; slot k is driven from edge 2+4k after accept.
  always @(negedge clk) begin : cmp
    int  s;
    bit  e_en, e_do, e_clk, e_end;
    if (mon_active && (abort_at == 0 || n < abort_at)) begin
      e_end = (n == 4 * L);
      e_clk = (n >= 4) && (n < 4 * L) && (((n - 4) % 4) < 2);
      e_en = 0; e_do = 0;
      if (n >= 2 && n < 4 * L) begin
        s = (n - 2) / 4;
        e_en = exp_en[s]; e_do = exp_do[s];
        if ((n - 2) % 4 == 0) begin got_do[s] = swdo; got_en[s] = swdo_en; end
      end
      chk("swdo_en", 32'(swdo_en), 32'(e_en));
      chk("swdo", 32'(swdo), 32'(e_do));
      chk("swclk_out", 32'(swclk_out), 32'(e_clk));
      chk("req_ready", 32'(req_ready), 32'(e_end));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_end));
      if (rsp_valid && valid_n < 0) valid_n = n;
      if (e_end) begin
        chk("rsp_ack", 32'(rsp_ack), 32'(exp_ack));
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_parity_err", 32'(rsp_parity_err), 32'(exp_perr));
      end
    end
  end

  function automatic logic [31:0] pack_got(input int base, input int cnt);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < cnt; i++) v[i] = got_do[base + i];
    return v;
  endfunction

  task automatic run_packet(input string tag, input bit lr, input bit ap, input bit rnw,
                            input logic [1:0] a, input logic [31:0] wd, input logic [2:0] ack_t,
                            input logic [31:0] rd_t, input bit bad_par, input bit hold_valid,
                            input int abrt);
    int s;
    int quiet;
    build_model(lr, ap, rnw, a, wd, ack_t, rd_t, bad_par);
    abort_at = abrt;
    valid_n = -1;
    for (int i = 0; i < 64; i++) begin got_do[i] = 0; got_en[i] = 0; end
    @(negedge clk);
    chk({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    req_valid = 1; req_linereset = lr; req_ap_ndp = ap; req_r_nw = rnw;
    req_addr = a; req_wdata = wd;
    @(posedge clk);
    n = 0;
    mon_active = 1;
    #1;
    if (!hold_valid) req_valid = 0;
    req_linereset = ~lr; req_ap_ndp = ~ap; req_r_nw = ~rnw; req_addr = ~a; req_wdata = ~wd;
    for (int k = 1; k <= 4 * L; k++) begin
      @(posedge clk);
      n = k;
      if (abrt != 0 && k == abrt) break;
      #1;
      if (k >= 2) begin
        s = (k - 2) / 4;
        swdi = (s < L) ? tgt[s] : 1'b0;
      end
      if (hold_valid && k == 4 * L - 2) req_valid = 0;
      if (abrt != 0 && k == abrt - 1) rst = 1;
    end
    @(negedge clk);
    if (abrt != 0) begin
      chk({tag, "_rst_swdo_en"}, 32'(swdo_en), 32'd0);
      chk({tag, "_rst_swdo"}, 32'(swdo), 32'd0);
      chk({tag, "_rst_swclk"}, 32'(swclk_out), 32'd0);
      chk({tag, "_rst_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rst_valid"}, 32'(rsp_valid), 32'd0);
      #1;
      rst = 0;
      mon_active = 0;
      quiet = 0;
      repeat (80) begin
        @(negedge clk);
        if (rsp_valid || swclk_out || swdo_en) quiet++;
      end
      chk({tag, "_quiet_after_rst"}, 32'(quiet), 32'd0);
    end else begin
      #1 mon_active = 0;
    end
    swdi = 0;
    req_valid = 0;
  endtask

  initial begin
    rst = 1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_swclk", 32'(swclk_out), 32'd0);
      chk("reset_swdo", 32'(swdo), 32'd0);
      chk("reset_swdo_en", 32'(swdo_en), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset_rsp_ack", 32'(rsp_ack), 32'd0);
      chk("reset_rsp_rdata", rsp_rdata, 32'd0);
      chk("reset_parity_err", 32'(rsp_parity_err), 32'd0);
      chk("reset_req_ready", 32'(req_ready), 32'd1);
    end
    rst = 0;

    // DPIDR read.
    run_packet("dpidr", 0, 0, 1, 2'd0, 32'h0, 3'b001, 32'h0BC12477, 0, 0, 0);
    chk("dpidr_header", pack_got(0, 8), 32'hA5);
    chk("dpidr_latency", 32'(valid_n), 32'd192);
    chk("dpidr_ack", 32'(rsp_ack), 32'h1);
    chk("dpidr_rdata", rsp_rdata, 32'h0BC12477);
    chk("dpidr_perr", 32'(rsp_parity_err), 32'd0);

    // AP write.
    run_packet("apw", 0, 1, 0, 2'd1, 32'hDEADBEEF, 3'b001, 32'h0, 0, 0, 0);
    chk("apw_header", pack_got(0, 8), 32'h8B);
    chk("apw_data", pack_got(13, 32), 32'hDEADBEEF);
    chk("apw_parity", 32'(got_do[45]), 32'd0);
    chk("apw_turn_released", 32'(got_en[12]), 32'd0);
    chk("apw_data_driven", 32'(got_en[13]), 32'd1);
    chk("apw_rdata_zero", rsp_rdata, 32'd0);

    // WAIT, with req_valid held (and fields scrambled) while busy.
    run_packet("wait", 0, 0, 1, 2'd3, 32'h0, 3'b010, 32'hFFFFFFFF, 0, 1, 0);
    chk("wait_latency", 32'(valid_n), 32'd60);
    chk("wait_ack", 32'(rsp_ack), 32'h2);
    chk("wait_rdata", rsp_rdata, 32'd0);

    // FAULT on a write.
    run_packet("fault", 0, 1, 0, 2'd2, 32'h12345678, 3'b100, 32'h0, 0, 0, 0);
    chk("fault_ack", 32'(rsp_ack), 32'h4);

    // Read with corrupted parity.
    run_packet("badpar", 0, 1, 1, 2'd3, 32'h0, 3'b001, 32'h00000001, 1, 0, 0);
    chk("badpar_perr", 32'(rsp_parity_err), 32'd1);
    chk("badpar_rdata", rsp_rdata, 32'h00000001);

    // Line reset.
    run_packet("lreset", 1, 0, 0, 2'd0, 32'h0, 3'b000, 32'h0, 0, 0, 0);
    chk("lreset_ones", 32'($countones(pack_got(0, 32)) + $countones(pack_got(32, 24))), 32'd56);
    chk("lreset_trail", 32'({got_do[56], got_do[57], got_en[56], got_en[57]}), 32'b0011);
    chk("lreset_ack", 32'(rsp_ack), 32'd0);
    chk("lreset_latency", 32'(valid_n), 32'd232);

    // Write aborted by reset during the data phase (slot 20).
    run_packet("abort", 0, 0, 0, 2'd2, 32'hCAFEF00D, 3'b001, 32'h0, 0, 0, 83);

    // Recovery after abort.
    run_packet("recover", 0, 0, 1, 2'd1, 32'h0, 3'b001, 32'hA5A50F0F, 0, 0, 0);
    chk("recover_rdata", rsp_rdata, 32'hA5A50F0F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/opendap_swd_host_serial.md
# opendap_swd_host_serial

Host-side (probe/initiator) SWD serial engine: the opposite end of the wire from the SW-DP serial comms block. It accepts one parallel DP/AP access request at a time and generates SWCLK from the system clock. It shifts out the 8-bit packet header, turns the line around, samples the 3-bit ACK, then moves 32-bit data plus parity in the required direction and returns a parallel response. It also issues line-reset sequences on request. It sits between the probe's command processor and the SWD pins.

## Interface
- `CLKDIV`, default 2: SWCLK half-period in `clk` cycles (≥1).
- `IDLE_CYCLES`, default 2: trailing idle SWCLK cycles, SWDIO driven 0, after every packet.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `swclk_out`  out  1  generated SWCLK.
- `swdo` / `swdo_en`  out  1 / 1  SWDIO output value / output enable.
- `swdi`  in  1  SWDIO input, already synchronised by the pad wrapper.
- `req_valid` / `req_ready`  in / out  1 / 1  request handshake.
- `req_linereset`  in  1  1 = issue a line reset instead of an access.
- `req_ap_ndp`, `req_r_nw`  in  1 each  header APnDP, RnW.
- `req_addr`  in  2  header A[3:2].
- `req_wdata`  in  32  write data.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_ack`  out  3  raw ACK, bit 0 is the first bit sampled.
- `rsp_rdata`  out  32  read data.
- `rsp_parity_err`  out  1  read parity mismatch.

## Operation
- Accept: request accepted on a `clk` edge with `req_valid && req_ready`. `req_ready` = (state == IDLE). All request fields are captured at acceptance.
- SWCLK rules:
  - `swclk_out` is held low in IDLE.
  - When active, it toggles every `CLKDIV` clk cycles.
  - Host output bits change on the falling tick.
  - `swdi` is sampled on the clk cycle of the rising tick.
- States and transitions:
  - IDLE → HEADER, or IDLE → LINERESET if `req_linereset`.
  - HEADER: 8 bits, LSB first: start=1, APnDP, RnW, A2, A3, parity (XOR of the previous four), stop=0, park=1.
  - TURN_ACK: 1 cycle, `swdo_en`=0.
  - ACK: 3 bits sampled.
  - ACK=3'b001 (OK) with read → RDATA: 32 data bits plus 1 parity bit sampled, then TURN_RD (1 cycle), then TRAIL.
  - ACK=3'b001 (OK) with write → TURN_WR (1 cycle), then WDATA: 32 bits plus even parity driven, then TRAIL.
  - Any other ACK (WAIT 3'b010, FAULT 3'b100, or protocol error) → TURN_NAK (1 cycle), then TRAIL. No data phase is run.
  - LINERESET: 56 cycles of `swdo`=1, then TRAIL.
  - TRAIL: `IDLE_CYCLES` cycles with `swdo`=0, `swdo_en`=1, then IDLE.
- Overrun detection (ORUNDETECT) on the target is unsupported. Software must keep it clear.
- Response:
  - `rsp_valid` pulses for one clk cycle on the TRAIL→IDLE transition.
  - `rsp_ack`: the sampled ACK. It is 3'b000 for a line reset.
  - `rsp_rdata`: shifted-in data for an OK read, otherwise 0.
  - `rsp_parity_err`: 1 only on an OK read whose sampled parity ≠ XOR of the received data. Data is still returned.
- `swdo_en` is 1 in every state except IDLE and the turnaround and sampling phases (TURN_*, ACK, RDATA).

## Timing
- Reset values:
  - `swclk_out`, `swdo`, `swdo_en`, `rsp_valid`, `rsp_parity_err` = 0.
  - `rsp_ack` = 0, `rsp_rdata` = 0.
  - state = IDLE, so `req_ready` = 1.
- `rst` asserted mid-packet: all outputs take their reset values on the next clk edge. The packet is abandoned and no `rsp_valid` is generated.
- Packet length in SWCLK cycles:
  - OK read: 8+1+3+33+1+`IDLE_CYCLES`.
  - OK write: 8+1+3+1+33+`IDLE_CYCLES`.
  - Non-OK: 8+1+3+1+`IDLE_CYCLES`.
  - Line reset: 56+`IDLE_CYCLES`.
- Each SWCLK cycle lasts 2·`CLKDIV` clk cycles.
- The first falling tick, which drives the start bit, occurs `CLKDIV` clk cycles after acceptance.
- `req_ready` returns high in the same cycle as `rsp_valid`. A back-to-back request may be accepted on that edge.
- `req_valid` while busy is ignored.

## Structure
- Shared package `opendap_swd_pkg` holds:
  - ACK constants (OK/WAIT/FAULT).
  - Host state encoding.
  - `LINERESET_LEN` = 56.
- Sub-module `opendap_swd_host_clkgen` contains the divider. It emits `swclk_out`, a `fall_tick` pulse and a `rise_tick` pulse, and is enabled by state ≠ IDLE.
- The main FSM, bit counter, 32-bit shift register and parity accumulator live in the top module.

## Test plan
(All scenarios use `CLKDIV`=2, `IDLE_CYCLES`=2.)
- Reset: assert `rst` 3 cycles → all outputs 0, `req_ready`=1, `swclk_out` static low.
- DPIDR read (ap_ndp=0, r_nw=1, addr=0):
  - Header bits are 1,0,1,0,0,1,0,1.
  - Target model returns ACK OK and 0x0BC12477 with correct parity.
  - Expect `rsp_ack`=3'b001, `rsp_rdata`=0x0BC12477, `rsp_parity_err`=0, `rsp_valid` 192 clk cycles after accept.
- AP write (ap_ndp=1, r_nw=0, addr=1, wdata=0xDEADBEEF):
  - Header bits are 1,1,0,1,0,0,0,1.
  - ACK OK → data driven LSB first, parity bit = 0, `swdo_en`=0 for exactly one turnaround SWCLK before the data.
- WAIT: model drives ACK 0,1,0 → `rsp_ack`=3'b010, no data phase, total 15 SWCLK cycles.
- Bad read parity: model flips the parity bit on 0x00000001 → `rsp_parity_err`=1, `rsp_rdata`=0x00000001.
- Line reset then mid-packet reset:
  - Line reset → 56 ones then 2 zeros, `rsp_ack`=0.
  - Next write with `rst` asserted during WDATA → `swdo_en`=0 on the next clk, no `rsp_valid`.
